// File: rtl/uart_multi_beacon.sv
// uart_multi_beacon: NUM_CH UART beacon lines that shift in lockstep.
// The lines share one baud counter and one sequencer. Each line repeats its own
// MSG_LEN-character message. There is an idle gap of PERIOD_MS between messages.
// Optional feature macro: UART_BEACON_CRLF_EN appends 0x0D,0x0A to every message.

// Per-line bit generator: selects the character and bit that the shared
// sequencer points at, and registers the serial output.
module uart_beacon_lane #(
  parameter int MSG_LEN   = 5,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int CW        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSG_LEN*8-1:0] msg,
  input  logic [CW-1:0]        char_idx,
  input  logic [1:0]           phase,
  input  logic [2:0]           bit_idx,
  output logic                 tx
);
  localparam logic [1:0] PH_START = 2'd1, PH_DATA = 2'd2, PH_PAR = 2'd3;
  localparam logic [7:0] DMASK    = 8'hFF >> (8 - DATA_BITS);

  logic [7:0] chr;
  logic       tx_d, tx_q;

  // Character 0 is the most-significant byte of the lane slice.
  always_comb begin
    chr = 8'hFF;
    for (int k = 0; k < MSG_LEN; k++)
      if (char_idx == CW'(k)) chr = msg[(MSG_LEN-1-k)*8 +: 8];
`ifdef UART_BEACON_CRLF_EN
    if (char_idx == CW'(MSG_LEN))     chr = 8'h0D;
    if (char_idx == CW'(MSG_LEN + 1)) chr = 8'h0A;
`endif
  end

  // Line level for the bit being entered; the stop bit, gap and idle phases are all high.
  always_comb begin
    tx_d = 1'b1;
    case (phase)
      PH_START: tx_d = 1'b0;
      PH_DATA:  tx_d = chr[bit_idx];
      PH_PAR:   tx_d = (PARITY == 1) ? ~^(chr & DMASK) : ^(chr & DMASK);
      default:  tx_d = 1'b1;
    endcase
  end

  // Registered serial output. Reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx_q <= 1'b1;
    else        tx_q <= tx_d;

  assign tx = tx_q;
endmodule

module uart_multi_beacon #(
  parameter int CLK_FRE   = 25,
  parameter int UART_RATE = 115200,
  parameter int NUM_CH    = 4,
  parameter int MSG_LEN   = 5,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int PERIOD_MS = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_CH*MSG_LEN*8-1:0] msg_data,
  output logic [NUM_CH-1:0]           uart_tx,
  output logic                        busy,
  output logic                        msg_done
);
`ifdef UART_BEACON_CRLF_EN
  localparam int NCHARS = MSG_LEN + 2;
`else
  localparam int NCHARS = MSG_LEN;
`endif
  localparam int          CW        = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [31:0] RATE_CNT  = 32'(CLK_FRE * 1000000 / UART_RATE - 1);
  localparam logic [31:0] GAP_CNT   = 32'(PERIOD_MS * CLK_FRE * 1000);
  localparam logic [CW-1:0] LAST_CHAR = CW'(NCHARS - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [1:0]  PH_HIGH = 2'd0, PH_START = 2'd1, PH_DATA = 2'd2, PH_PAR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 baud_q, baud_d, gap_q, gap_d;
  logic [2:0]                  bit_q, bit_d;
  logic                        stop_q, stop_d;
  logic [CW-1:0]               char_q, char_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [NUM_CH*MSG_LEN*8-1:0] msg_q, msg_d;
  logic [1:0]                  phase_d;
  logic                        bit_end;

  assign bit_end = (baud_q == RATE_CNT);

  // Sequencer next state. The baud counter restarts at 0 on entry to every bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 32'd1;
    gap_d   = gap_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    char_d  = char_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    msg_d   = msg_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (en) begin
          state_d = S_START; msg_d = msg_data; char_d = '0; busy_d = 1'b1;
        end
      end
      S_START: if (bit_end) begin
        baud_d = '0; bit_d = '0; state_d = S_DATA;
      end
      S_DATA: if (bit_end) begin
        baud_d = '0;
        if (bit_q == LAST_BIT) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP; stop_d = 1'b0;
        end else bit_d = bit_q + 3'd1;
      end
      S_PAR: if (bit_end) begin
        baud_d = '0; stop_d = 1'b0; state_d = S_STOP;
      end
      S_STOP: if (bit_end) begin
        baud_d = '0;
        if (stop_q != LAST_STOP) stop_d = 1'b1;
        else if (char_q == LAST_CHAR) begin
          state_d = S_GAP; gap_d = '0; done_d = 1'b1; busy_d = 1'b0;
        end else begin
          char_d = char_q + CW'(1); state_d = S_START;
        end
      end
      S_GAP: begin
        baud_d = '0;
        gap_d  = gap_q + 32'd1;
        if (gap_q == GAP_CNT - 32'd1) begin
          if (en) begin
            state_d = S_START; msg_d = msg_data; char_d = '0; busy_d = 1'b1;
          end else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The lanes register the line level for the state being entered, so uart_tx tracks state_q.
  always_comb begin
    phase_d = PH_HIGH;
    case (state_d)
      S_START: phase_d = PH_START;
      S_DATA:  phase_d = PH_DATA;
      S_PAR:   phase_d = PH_PAR;
      default: phase_d = PH_HIGH;
    endcase
  end

  // Sequencer state, counters, latched message and status flags.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      char_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      char_q  <= char_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      msg_q   <= msg_d;
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    uart_beacon_lane #(
      .MSG_LEN(MSG_LEN), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .CW(CW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .msg      (msg_q[c*MSG_LEN*8 +: MSG_LEN*8]),
      .char_idx (char_d),
      .phase    (phase_d),
      .bit_idx  (bit_d),
      .tx       (uart_tx[c])
    );
  end

  assign busy     = busy_q;
  assign msg_done = done_q;
endmodule

// File: tb/tb_uart_multi_beacon.sv
// Directed bench for uart_multi_beacon: 8N1 two-channel main instance,
// plus one 7O1 instance and one 8E2 instance for the parity and stop-bit framing.
module tb_uart_multi_beacon;
`ifdef UART_BEACON_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NF     = 2 + EXTRA;          // frames per main message
  localparam int MSGC   = NF * 100;           // main message length, cycles
  localparam int P_DONE = (1 + EXTRA) * 100;  // 7O1: 10-bit frames
  localparam int E_DONE = (1 + EXTRA) * 120;  // 8E2: 12-bit frames

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [31:0] msg_data;
  logic [1:0]  uart_tx;
  logic        busy, msg_done;
  logic        tx_p, busy_p, done_p, tx_e, busy_e, done_e;

  int          t, checks, failures;
  logic [63:0] obs0, obs1, obs_p, obs_e;

  always #5 clk = ~clk;

  uart_multi_beacon #(.CLK_FRE(1), .UART_RATE(100000), .NUM_CH(2), .MSG_LEN(2),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .PERIOD_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .msg_data(msg_data),
    .uart_tx(uart_tx), .busy(busy), .msg_done(msg_done));

  uart_multi_beacon #(.CLK_FRE(1), .UART_RATE(100000), .NUM_CH(1), .MSG_LEN(1),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .PERIOD_MS(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .en(en), .msg_data(8'h55),
    .uart_tx(tx_p), .busy(busy_p), .msg_done(done_p));

  uart_multi_beacon #(.CLK_FRE(1), .UART_RATE(100000), .NUM_CH(1), .MSG_LEN(1),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .PERIOD_MS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .en(en), .msg_data(8'h03),
    .uart_tx(tx_e), .busy(busy_e), .msg_done(done_e));

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); t++; end
  endtask

  task automatic goto(input int target);
    while (t < target) step(1);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample both main lanes at the middle of bit times b0..b1-1 of a message starting at t0.
  task automatic cap_main(input int t0, input int b0, input int b1);
    for (int b = b0; b < b1; b++) begin
      goto(t0 + 5 + 10 * b);
      obs0[b] = uart_tx[0];
      obs1[b] = uart_tx[1];
    end
  endtask

  // 8N1 frame as seen on the wire: bit i of the word = bit time i.
  task automatic chk_pair(input string tag, input logic [7:0] a1, input logic [7:0] b1,
                          input logic [7:0] a0, input logic [7:0] b0);
    chk({tag, "_ch1_f0"}, obs1[9:0],   {1'b1, a1, 1'b0});
    chk({tag, "_ch1_f1"}, obs1[19:10], {1'b1, b1, 1'b0});
    chk({tag, "_ch0_f0"}, obs0[9:0],   {1'b1, a0, 1'b0});
    chk({tag, "_ch0_f1"}, obs0[19:10], {1'b1, b0, 1'b0});
  endtask

  initial begin
    t = 0; checks = 0; failures = 0;
    obs0 = '0; obs1 = '0; obs_p = '0; obs_e = '0;
    rst_n = 1'b0; en = 1'b0; msg_data = 32'h41424344;   // ch1 "AB", ch0 "CD"
    step(3);
    chk("reset_tx", uart_tx, 2'b11);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", msg_done, 1'b0);
    chk("reset_tx_par", {tx_e, tx_p}, 2'b11);
    rst_n = 1'b1;
    step(3);
    chk("idle_tx", uart_tx, 2'b11);
    chk("idle_busy", busy, 1'b0);

    // Message 1: start bit in the first cycle after en is sampled.
    en = 1'b1;
    step(1); t = 0;
    chk("start_latency", uart_tx, 2'b00);
    chk("start_latency_par", {tx_e, tx_p}, 2'b00);
    chk("busy_rise", busy, 1'b1);
    for (int k = 1; k <= MSGC + 1; k++) begin
      goto(k);
      if (k % 10 == 5) begin
        obs0[k/10] = uart_tx[0];
        obs1[k/10] = uart_tx[1];
        if (k / 10 < 10) obs_p[k/10] = tx_p;
        if (k / 10 < 12) obs_e[k/10] = tx_e;
      end
      if (k == 55) msg_data = 32'h5758595A;             // ch1 "WX", ch0 "YZ"
      if (k == P_DONE - 1) chk("p_busy_last_stop", {busy_p, done_p}, 2'b10);
      if (k == P_DONE)     chk("p_done_pulse", {busy_p, done_p}, 2'b01);
      if (k == E_DONE - 1) chk("e_second_stop", {tx_e, done_e}, 2'b10);
      if (k == E_DONE)     chk("e_done_pulse", {busy_e, done_e}, 2'b01);
      if (k == MSGC - 1)   chk("busy_last_cycle", {busy, msg_done, uart_tx}, 4'b1011);
      if (k == MSGC)       chk("done_pulse", {busy, msg_done}, 2'b01);
      if (k == MSGC + 1)   chk("done_one_cycle", msg_done, 1'b0);
    end
    chk_pair("msg1", 8'h41, 8'h42, 8'h43, 8'h44);
`ifdef UART_BEACON_CRLF_EN
    chk("crlf_cr", obs1[29:20], {1'b1, 8'h0D, 1'b0});
    chk("crlf_lf", obs0[39:30], {1'b1, 8'h0A, 1'b0});
`endif
    chk("par_odd_7bit", obs_p[9:0], 10'b1110101010);
    chk("par_even_2stop", obs_e[11:0], 12'b110000000110);

    // Gap of 1000 cycles, then restart with the newly latched message.
    goto(MSGC + 999);
    chk("gap_tx", {busy, uart_tx}, 3'b011);
    goto(MSGC + 1000);
    chk("gap_end_restart", {busy, uart_tx}, 3'b100);

    // Message 2: en drops during character 0; the message still completes.
    cap_main(MSGC + 1000, 0, 3);
    en = 1'b0;
    cap_main(MSGC + 1000, 3, 20);
    chk_pair("msg2", 8'h57, 8'h58, 8'h59, 8'h5A);
    goto(MSGC + 1000 + MSGC);
    chk("msg2_done", {busy, msg_done}, 2'b01);
    goto(2 * MSGC + 2000);
    chk("no_restart", {busy, uart_tx}, 3'b011);
    goto(2 * MSGC + 2010);
    chk("stays_idle", {busy, uart_tx}, 3'b011);

    // From IDLE: immediate start, then async reset in character 1.
    msg_data = 32'h31323334;                              // ch1 "12", ch0 "34"
    en = 1'b1;
    step(1); t = 0;
    chk("idle_start", {busy, uart_tx}, 3'b100);
    goto(125);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", uart_tx, 2'b11);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tx_par", {tx_e, tx_p}, 2'b11);
    step(2);
    chk("rst_hold", {busy, msg_done, uart_tx}, 4'b0011);
    rst_n = 1'b1;
    step(1); t = 0;
    chk("fresh_start", {busy, uart_tx}, 3'b100);
    cap_main(0, 0, 20);
    chk_pair("fresh", 8'h31, 8'h32, 8'h33, 8'h34);

    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_multi_beacon.md
Name: uart_multi_beacon

Overview:
- Parametrised multi-channel UART beacon transmitter; successor to the fixed 8N1, one-instance-per-pin identifier sender used on the all-IO board test.
- NUM_CH transmit lines share one baud counter and one sequencer, and shift out in lockstep. Each channel has its own MSG_LEN-character message.
- Repeats the message every PERIOD_MS while enabled.
- Adds configurable data bits, parity, stop bits, enable gating, busy/done status, and an asynchronous reset.

Parameters:
- CLK_FRE, 25, system clock in MHz.
- UART_RATE, 115200, baud rate.
- NUM_CH, 4, number of tx channels (1..256).
- MSG_LEN, 5, characters per message per channel (1..64).
- DATA_BITS, 8, data bits per character (5..8).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits (1 or 2).
- PERIOD_MS, 1000, idle gap in ms between the end of one message and the next start bit.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, level enable; messages repeat while high.
- msg_data, input, NUM_CH*MSG_LEN*8, channel c occupies bits [(c+1)*MSG_LEN*8-1 : c*MSG_LEN*8]. Within a channel slice, character 0 is the most-significant byte (string-literal order).
- uart_tx, output, NUM_CH, serial lines, idle high.
- busy, output, 1, high from the first start bit through the last stop bit of a message.
- msg_done, output, 1, one-cycle pulse after the last stop bit of each message.

Behaviour:
- Reset, asynchronous: uart_tx = all ones, busy = 0, msg_done = 0. State becomes IDLE and all counters clear. Reset mid-character forces the lines high immediately, with no partial stop bit.
- All outputs are registered.
- Bit time is RATE_CNT+1 cycles, where RATE_CNT = CLK_FRE*1_000_000/UART_RATE - 1 (integer division).
- The baud counter is free of drift: it restarts at 0 on entry to every bit.
- States and transitions:
  - IDLE → START when en is sampled high. msg_data is latched into an internal message register on that edge. Inputs are not sampled again until the next message.
  - START: drive 0 for one bit time → DATA.
  - DATA: DATA_BITS bits, LSB first, taken from the character's low DATA_BITS bits → PARITY if PARITY != 0, else STOP.
  - PARITY: for odd parity, the bit makes the total count of ones (data + parity) odd; for even parity, even → STOP.
  - STOP: drive 1 for STOP_BITS bit times. If more characters remain, go to START for the next character with no inter-character gap. After the last character, pulse msg_done and go to GAP.
  - GAP: lines high for PERIOD_MS*CLK_FRE*1000 cycles (32-bit counter). When the count expires, go to START with a new latch if en = 1, else IDLE.
- Latency: en high sampled at edge N puts uart_tx low from edge N+1.
- busy: rises together with the start bit and falls when the GAP or IDLE state is entered.
- Character frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit times.
- en dropped mid-message: the current message completes in full, then GAP, then IDLE. en dropped during GAP: go to IDLE at the end of GAP.
- en re-asserted during GAP: no early start; the next message starts at the end of GAP.
- msg_data changes mid-message have no effect until the next latch.
- All channels switch bits on the same clock edge.

Optional Feature:
- Macro: UART_BEACON_CRLF_EN.
- Defined: two extra characters, 0x0D then 0x0A, are appended after the MSG_LEN characters on every channel, using the same framing. msg_done follows the 0x0A stop bit. Frames per message = MSG_LEN + 2.
- Undefined: exactly MSG_LEN characters are sent, with no terminator.

Test Plan:
- Common settings unless stated: CLK_FRE=1, UART_RATE=100000 (10 cycles/bit), PERIOD_MS=1, 8N1.
- Test 1: NUM_CH=2, MSG_LEN=2, msg_data={"AB","CD"}, en=1 from cycle 0 → ch1 sends 0x41, 0x42 and ch0 sends 0x43, 0x44. Each frame is 100 cycles; busy is high for 200 cycles; msg_done pulses at cycle 201. The next start bit comes 1000 cycles later.
- Test 2: PARITY=1, DATA_BITS=7, char 0x55 → bits (LSB first) 1,0,1,0,1,0,1, then parity 1 (4 ones + 1 = 5, odd). Frame is 10 bit times.
- Test 3: STOP_BITS=2, PARITY=2, char 0x03 → even parity bit 0, stop level held 20 cycles. The frame is 12 bit times = 120 cycles.
- Test 4: deassert en during character 1 of a 5-character message → all 5 characters complete, msg_done pulses, GAP runs, then IDLE. No further start bit appears.
- Test 5: assert rst_n=0 mid-data-bit → uart_tx goes all-ones and busy goes 0 asynchronously. After release with en=1, a fresh message starts from character 0.
- Test 6: with UART_BEACON_CRLF_EN defined, MSG_LEN=1, "Z" → frames 0x5A, 0x0D, 0x0A. msg_done pulses after the third frame (cycle 301).
